// File: rtl/wb_pkg.sv
// Shared writeback types and constants for the register-file writeback arbiter.
// The optional hazard bypass is controlled by the WB_ARB_BYPASS_EN macro in the top module.
package wb_pkg;

  localparam int NUM_REQ = 2;

  typedef logic [3:0]  addr_t;
  typedef logic [31:0] data_t;

  // Register 15 is the PC. Writes to it are dropped and it is never tracked as busy.
  localparam addr_t PC_REG = 4'hF;

endpackage : wb_pkg

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant for the writeback port, with a one-bit last-grant pointer.
// The pointer resets to 1 so that requester 0 wins the first contention.
module rr_arbiter2
  import wb_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] valid_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic last_q;
  logic last_d;

  // NOTE: every signal written in always_comb gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    grant_o = '0;
    if (!reset) begin
      if (&valid_i) begin
        grant_o = last_q ? 2'b01 : 2'b10;
      end else begin
        grant_o = valid_i;
      end
    end
  end

  // Because a grant only goes to a valid requester, every grant is a transfer.
  always_comb begin
    last_d = last_q;
    if (|grant_o) begin
      last_d = grant_o[1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule : rr_arbiter2

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the ALU and memory writeback paths onto one register-file write port and tracks busy registers.
// When WB_ARB_BYPASS_EN is defined, a write in flight suppresses the matching hazard and drives fwd1_hit/fwd2_hit.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  input  logic          alloc_valid,
  input  logic [AW-1:0] alloc_addr,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic          hazard,
  output logic          we3,
  output logic [AW-1:0] wa3,
  output logic [DW-1:0] wd3,
  output logic          err_r15
`ifdef WB_ARB_BYPASS_EN
  ,
  output logic          fwd1_hit,
  output logic          fwd2_hit
`endif
);

  localparam logic [AW-1:0] PC_ADDR  = AW'(PC_REG);
  localparam int            NUM_BUSY = (1 << AW) - 1;

  logic [NUM_REQ-1:0] valid;
  logic [NUM_REQ-1:0] grant;
  logic               xfer;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_data;

  logic               we3_q, we3_d;
  logic [AW-1:0]      wa3_q, wa3_d;
  logic [DW-1:0]      wd3_q, wd3_d;
  logic               err_q, err_d;
  logic [NUM_BUSY-1:0] busy_q, busy_d;

  assign valid = {req1_valid, req0_valid};

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .valid_i (valid),
    .grant_o (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign xfer       = |grant;
  assign sel_addr   = grant[1] ? req1_addr : req0_addr;
  assign sel_data   = grant[1] ? req1_data : req0_data;

  always_comb begin
    we3_d = xfer && (sel_addr != PC_ADDR);
    err_d = xfer && (sel_addr == PC_ADDR);
    wa3_d = wa3_q;
    wd3_d = wd3_q;
    if (we3_d) begin
      wa3_d = sel_addr;
      wd3_d = sel_data;
    end
    // Clear for the committed write first, then set for the new allocation, so set wins.
    busy_d = busy_q;
    for (int i = 0; i < NUM_BUSY; i++) begin
      if (we3_q && (wa3_q == AW'(i))) busy_d[i] = 1'b0;
      if (alloc_valid && (alloc_addr == AW'(i))) busy_d[i] = 1'b1;
    end
  end

  // NOTE: the busy mask is reset explicitly because stale bits would stall the pipeline forever.
  always_ff @(posedge clk) begin
    if (reset) begin
      we3_q  <= 1'b0;
      wa3_q  <= '0;
      wd3_q  <= '0;
      err_q  <= 1'b0;
      busy_q <= '0;
    end else begin
      we3_q  <= we3_d;
      wa3_q  <= wa3_d;
      wd3_q  <= wd3_d;
      err_q  <= err_d;
      busy_q <= busy_d;
    end
  end

  assign we3     = we3_q;
  assign wa3     = wa3_q;
  assign wd3     = wd3_q;
  assign err_r15 = err_q;

  // The extra top bit stands for the PC, which always reads as not busy.
  logic [NUM_BUSY:0] busy_ext;
  logic              hz1;
  logic              hz2;

  assign busy_ext = {1'b0, busy_q};
  assign hz1      = busy_ext[ra1];
  assign hz2      = busy_ext[ra2];

`ifdef WB_ARB_BYPASS_EN
  assign fwd1_hit = we3_q && (wa3_q == ra1);
  assign fwd2_hit = we3_q && (wa3_q == ra2);
  assign hazard   = (hz1 && !fwd1_hit) || (hz2 && !fwd2_hit);
`else
  assign hazard   = hz1 || hz2;
`endif

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a per-cycle behavioural model and literal spot checks.
// Build with WB_ARB_BYPASS_EN defined to exercise the forwarding outputs.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [3:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        alloc_valid;
  logic [3:0]  alloc_addr;
  logic [3:0]  ra1, ra2;
  logic        hazard;
  logic        we3;
  logic [3:0]  wa3;
  logic [31:0] wd3;
  logic        err_r15;
`ifdef WB_ARB_BYPASS_EN
  logic        fwd1_hit, fwd2_hit;
`endif

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  regfile_wb_arbiter #(.DW(32), .AW(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_addr   (req0_addr),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_addr   (req1_addr),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .ra1         (ra1),
    .ra2         (ra2),
    .hazard      (hazard),
    .we3         (we3),
    .wa3         (wa3),
    .wd3         (wd3),
    .err_r15     (err_r15)
`ifdef WB_ARB_BYPASS_EN
    ,
    .fwd1_hit    (fwd1_hit),
    .fwd2_hit    (fwd2_hit)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Model state: the write due this cycle, the r15 error pulse, the busy set and the last winner.
  bit          m_we   = 1'b0;
  logic [3:0]  m_wa   = '0;
  logic [31:0] m_wd   = '0;
  bit          m_err  = 1'b0;
  bit [15:0]   m_busy = '0;
  int          m_last = 1;

  always @(negedge clk) begin : model
    int          g;
    bit          f1, f2, ehz;
    logic [3:0]  a;
    logic [31:0] d;
    g = -1;
    if (!reset) begin
      if (req0_valid && req1_valid) g = (m_last == 1) ? 0 : 1;
      else if (req0_valid)          g = 0;
      else if (req1_valid)          g = 1;
    end
`ifdef WB_ARB_BYPASS_EN
    f1 = m_we && (m_wa == ra1);
    f2 = m_we && (m_wa == ra2);
`else
    f1 = 1'b0;
    f2 = 1'b0;
`endif
    ehz = (ra1 != 4'hF && m_busy[ra1] && !f1) || (ra2 != 4'hF && m_busy[ra2] && !f2);
    if (cmp_en) begin
      check("m_ready0", req0_ready, g == 0);
      check("m_ready1", req1_ready, g == 1);
      check("m_hazard", hazard, ehz);
      check("m_we3", we3, m_we);
      check("m_err", err_r15, m_err);
      if (m_we) begin
        check("m_wa3", wa3, m_wa);
        check("m_wd3", wd3, m_wd);
      end
`ifdef WB_ARB_BYPASS_EN
      check("m_fwd1", fwd1_hit, f1);
      check("m_fwd2", fwd2_hit, f2);
`endif
    end
    if (reset) begin
      m_we = 0; m_wa = '0; m_wd = '0; m_err = 0; m_busy = '0; m_last = 1;
    end else begin
      if (m_we) m_busy[m_wa] = 1'b0;
      if (alloc_valid && alloc_addr != 4'hF) m_busy[alloc_addr] = 1'b1;
      m_we  = 0;
      m_err = 0;
      if (g >= 0) begin
        a = (g == 1) ? req1_addr : req0_addr;
        d = (g == 1) ? req1_data : req0_data;
        m_last = g;
        if (a == 4'hF) m_err = 1;
        else begin
          m_we = 1; m_wa = a; m_wd = d;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0;
    req0_addr = '0; req1_addr = '0;
    req0_data = '0; req1_data = '0;
    alloc_valid = 0; alloc_addr = '0;
    ra1 = '0; ra2 = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cmp_en = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_we3", we3, 0);
    check("rst_wa3", wa3, 0);
    check("rst_wd3", wd3, 0);
    check("rst_err", err_r15, 0);
    check("rst_hazard", hazard, 0);

    // Single requester, one-cycle write latency
    next(); req0_valid = 1; req0_addr = 4'd3; req0_data = 32'hDEADBEEF;
    @(negedge clk);
    check("single_ready0", req0_ready, 1);
    check("single_ready1", req1_ready, 0);
    next(); req0_valid = 0;
    @(negedge clk);
    check("single_we3", we3, 1);
    check("single_wa3", wa3, 3);
    check("single_wd3", wd3, 32'hDEADBEEF);
    next();
    @(negedge clk);
    check("single_we3_off", we3, 0);

    // Contention right after reset alternates starting with req0
    next(); reset = 1;
    next(); reset = 0;
    req0_valid = 1; req0_addr = 4'd1; req0_data = 32'h1111_0001;
    req1_valid = 1; req1_addr = 4'd2; req1_data = 32'h2222_0002;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rr_ready0", req0_ready, (k % 2) == 0);
      check("rr_ready1", req1_ready, (k % 2) == 1);
      if (k > 0) check("rr_we3", we3, 1);
      next();
    end
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    check("rr_last_we3", we3, 1);
    check("rr_last_wa3", wa3, 2);
    check("rr_last_wd3", wd3, 32'h2222_0002);
    next();
    @(negedge clk);
    check("rr_we3_off", we3, 0);

    // Busy set by allocation, cleared the edge after the commit
    alloc_valid = 1; alloc_addr = 4'd5;
    next(); alloc_valid = 0; ra1 = 4'd5;
    @(negedge clk);
    check("busy5_hz", hazard, 1);
    next(); next();
    @(negedge clk);
    check("busy5_hold", hazard, 1);
    next(); req0_valid = 1; req0_addr = 4'd5; req0_data = 32'h0000_5555;
    @(negedge clk);
    check("busy5_pre", hazard, 1);
    next(); req0_valid = 0;
    @(negedge clk);
    check("busy5_we3", we3, 1);
    check("busy5_wa3", wa3, 5);
`ifdef WB_ARB_BYPASS_EN
    check("busy5_commit_hz", hazard, 0);
`else
    check("busy5_commit_hz", hazard, 1);
`endif
    next();
    @(negedge clk);
    check("busy5_clear", hazard, 0);
    ra1 = 4'd0;

    // Set and clear of the same register on one edge: set wins
    next(); req0_valid = 1; req0_addr = 4'd6; req0_data = 32'h6666_0006; ra2 = 4'd6;
    @(negedge clk);
    check("setwin_pre", hazard, 0);
    next(); req0_valid = 0; alloc_valid = 1; alloc_addr = 4'd6;
    @(negedge clk);
    check("setwin_wa3", wa3, 6);
    next(); alloc_valid = 0;
    @(negedge clk);
    check("setwin_hz", hazard, 1);
    next(); req0_valid = 1;
    next(); req0_valid = 0;
    next();
    @(negedge clk);
    check("setwin_cleared", hazard, 0);
    ra2 = 4'd0;

    // Two busy registers seen through both read ports
    next(); alloc_valid = 1; alloc_addr = 4'd12;
    next(); alloc_addr = 4'd2;
    next(); alloc_valid = 0; ra1 = 4'd12; ra2 = 4'd0;
    @(negedge clk);
    check("two_ra1", hazard, 1);
    ra1 = 4'd0; ra2 = 4'd2;
    #1 check("two_ra2", hazard, 1);
    ra2 = 4'd9;
    #1 check("two_none", hazard, 0);

    // Write to register 15 is dropped with a one-cycle error pulse
    next(); alloc_valid = 1; alloc_addr = 4'hF; ra1 = 4'hF; ra2 = 4'hF;
    req1_valid = 1; req1_addr = 4'hF; req1_data = 32'hFFFF_0000;
    @(negedge clk);
    check("r15_ready1", req1_ready, 1);
    check("r15_hz", hazard, 0);
    next(); alloc_valid = 0; req1_valid = 0;
    @(negedge clk);
    check("r15_we3", we3, 0);
    check("r15_err", err_r15, 1);
    next();
    @(negedge clk);
    check("r15_err_off", err_r15, 0);
    ra1 = 4'd12;
    #1 check("r15_busy_kept", hazard, 1);

    // Reset alongside a request: no grant, no write, busy cleared
    next(); req0_valid = 1; req0_addr = 4'd9; req0_data = 32'h9999_0009; reset = 1;
    @(negedge clk);
    check("rstreq_ready0", req0_ready, 0);
    check("rstreq_ready1", req1_ready, 0);
    next();
    @(negedge clk);
    check("rstreq_we3", we3, 0);
    check("rstreq_hz", hazard, 0);
    next(); reset = 0; req0_valid = 0;
    @(negedge clk);
    check("rstreq_we3_after", we3, 0);

    // Reset asserted right after an accepted transfer
    next(); req0_valid = 1; req0_addr = 4'd8; req0_data = 32'h8888_0008;
    alloc_valid = 1; alloc_addr = 4'd8; ra1 = 4'd8;
    @(negedge clk);
    check("midrst_ready0", req0_ready, 1);
    next(); req0_valid = 0; alloc_valid = 0; reset = 1;
    next(); reset = 0;
    @(negedge clk);
    check("midrst_we3", we3, 0);
    check("midrst_hz", hazard, 0);
    next();
    @(negedge clk);
    check("midrst_we3_late", we3, 0);

`ifdef WB_ARB_BYPASS_EN
    // Forwarding suppresses the hazard for the register being written
    next(); alloc_valid = 1; alloc_addr = 4'd7; ra1 = 4'd0;
    next(); alloc_valid = 0; req0_valid = 1; req0_addr = 4'd7; req0_data = 32'h7777_0007; ra2 = 4'd7;
    @(negedge clk);
    check("byp_pre_hz", hazard, 1);
    check("byp_pre_fwd2", fwd2_hit, 0);
    next(); req0_valid = 0;
    @(negedge clk);
    check("byp_hz", hazard, 0);
    check("byp_fwd2", fwd2_hit, 1);
    check("byp_fwd1", fwd1_hit, 0);
`endif

    next(); next();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_regfile_wb_arbiter
